qrd_feed_ctrl: RTL and testbench

//  Frame-level input scheduler for the N-column QRD-RLS systolic array.
//  - Accepts one input row (N x DATA_LENGTH) per valid/ready handshake.
//  - Drives the row into the array with a per-column skew: column k gets the row k cycles after column 0.
//  - Tracks each issued sample through the array's fixed latency and flags it at the array output.
//  - Sequences start / feed / drain / done for a frame of num_samples rows.

---
 rtl/qrd_feed_ctrl_pkg.sv | 16 +
 rtl/qrd_feed_ctrl_valid_delay_line.sv | 43 ++++
 rtl/qrd_feed_ctrl.sv | 124 ++++++++++++
 tb/tb_qrd_feed_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qrd_feed_ctrl_pkg.sv
// Shared types and default dimensions for the QRD-RLS array input scheduler.
package qrd_feed_ctrl_pkg;

  localparam int QRD_N           = 4;
  localparam int QRD_DATA_LENGTH = 8;
  localparam int QRD_PIPE_LAT    = 19;
  localparam int QRD_CNT_W       = 8;

  typedef enum logic [1:0] {
    QRD_IDLE  = 2'd0,
    QRD_FEED  = 2'd1,
    QRD_DRAIN = 2'd2,
    QRD_DONE  = 2'd3
  } qrd_state_e;

endpackage

// File: rtl/qrd_feed_ctrl_valid_delay_line.sv
// P-stage shift register carrying a valid bit (bit 0) plus payload; payload
// only advances alongside a set valid bit so idle stages hold their last value.
module valid_delay_line #(
  parameter int P = 1,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [P-1:0][W-1:0] stage_q;
  logic [P-1:0][W-1:0] stage_d;
  logic [P:0][W-1:0]   chain;

  assign chain = {stage_q, d_in};
  assign d_out = chain[P];

  // A flush drops only the valid bits; payload keeps its held value.
  always_comb begin
    stage_d = stage_q;
    for (int i = 0; i < P; i++) begin
      if (clr) begin
        stage_d[i][0] = 1'b0;
      end else if (chain[i][0]) begin
        stage_d[i] = chain[i];
      end else begin
        stage_d[i][0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/qrd_feed_ctrl.sv
// Frame-level input scheduler: accepts rows, skews them across the array
// columns, tracks each sample through the array latency and sequences the frame.
module qrd_feed_ctrl
  import qrd_feed_ctrl_pkg::*;
#(
  parameter int N           = QRD_N,
  parameter int DATA_LENGTH = QRD_DATA_LENGTH,
  parameter int PIPE_LAT    = QRD_PIPE_LAT,
  parameter int CNT_W       = QRD_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         num_samples,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*DATA_LENGTH-1:0] in_row,
  output logic [N*DATA_LENGTH-1:0] col_data,
  output logic [N-1:0]             col_valid,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  qrd_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] count_inc;
  logic             in_ready_q, busy_q, done_q;
  logic             accept, is_last;
  logic [1:0]       tag_out;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    num_d     = num_q;
    count_inc = count_q + CNT_W'(1);
    accept    = in_ready_q && in_valid && !abort;
    is_last   = accept && (count_inc == num_q);

    if (abort) begin
      state_d = QRD_IDLE;
    end else begin
      case (state_q)
        QRD_IDLE: begin
          if (start) begin
            num_d   = num_samples;
            count_d = '0;
            state_d = (num_samples == '0) ? QRD_DONE : QRD_FEED;
          end
        end
        QRD_FEED: begin
          if (accept) begin
            count_d = count_inc;
            if (count_inc == num_q) state_d = QRD_DRAIN;
          end
        end
        QRD_DRAIN: begin
          if (out_last) state_d = QRD_DONE;
        end
        default: state_d = QRD_IDLE;
      endcase
    end
  end

  // Handshake and status outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= QRD_IDLE;
      count_q    <= '0;
      num_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      num_q      <= num_d;
      in_ready_q <= (state_d == QRD_FEED);
      busy_q     <= (state_d != QRD_IDLE);
      done_q     <= (state_d == QRD_DONE);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Column k needs k+1 stages so its strobe lands k cycles after column 0.
  for (genvar k = 0; k < N; k++) begin : g_col
    logic [DATA_LENGTH:0] line_out;

    valid_delay_line #(
      .P(k + 1),
      .W(DATA_LENGTH + 1)
    ) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (abort),
      .d_in ({in_row[k*DATA_LENGTH +: DATA_LENGTH], accept}),
      .d_out(line_out)
    );

    assign col_valid[k]                            = line_out[0];
    assign col_data[k*DATA_LENGTH +: DATA_LENGTH] = line_out[DATA_LENGTH:1];
  end

  valid_delay_line #(
    .P(PIPE_LAT + 1),
    .W(2)
  ) u_tag (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort),
    .d_in ({is_last, accept}),
    .d_out(tag_out)
  );

  assign out_valid = tag_out[0];
  assign out_last  = tag_out[1] & tag_out[0];

endmodule

// File: tb/tb_qrd_feed_ctrl.sv
// Scoreboard bench for qrd_feed_ctrl: expected column strobes and array-output
// tags are queued with their due cycle when a row is driven and checked every cycle.
module tb_qrd_feed_ctrl;

  localparam int N   = 4;
  localparam int DL  = 8;
  localparam int PL  = 19;
  localparam int CW  = 8;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } col_exp_t;

  typedef struct {
    int cyc;
    bit last;
  } out_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*DL-1:0] in_row = '0;
  logic [N*DL-1:0] col_data;
  logic [N-1:0]  col_valid;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int exp_done_cyc = -1;

  col_exp_t cq [N][$];
  out_exp_t oq [$];

  qrd_feed_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .num_samples(num_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .col_data   (col_data),
    .col_valid  (col_valid),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic flush_expectations();
    for (int k = 0; k < N; k++) cq[k].delete();
    oq.delete();
  endtask

  // Per-cycle scoreboard check of every strobe, tag and the done pulse.
  always @(negedge clk) begin
    bit       exp_v;
    col_exp_t ce;
    out_exp_t oe;
    for (int k = 0; k < N; k++) begin
      exp_v = (cq[k].size() > 0) && (cq[k][0].cyc == cyc);
      checkOutput($sformatf("col_valid[%0d]", k), 64'(col_valid[k]), 64'(exp_v));
      if (exp_v) begin
        ce = cq[k].pop_front();
        checkOutput($sformatf("col_data[%0d]", k), 64'(col_data[k*DL +: DL]), 64'(ce.data));
      end
    end
    exp_v = (oq.size() > 0) && (oq[0].cyc == cyc);
    checkOutput("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      oe = oq.pop_front();
      checkOutput("out_last", 64'(out_last), 64'(oe.last));
    end else begin
      checkOutput("out_last_idle", 64'(out_last), 64'd0);
    end
    checkOutput("done", 64'(done), 64'(cyc == exp_done_cyc));
  end

  // All tasks enter and leave one time unit after a rising edge.
  task automatic start_frame(input logic [CW-1:0] n);
    start       = 1'b1;
    num_samples = n;
    if (n == 0) exp_done_cyc = cyc + 1;
    @(posedge clk); #1;
    start       = 1'b0;
    num_samples = 8'hA5;
  endtask

  task automatic applyStimulus(input logic [N*DL-1:0] row, input bit is_last);
    int e;
    checkOutput("in_ready_feed", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_row   = row;
    e        = cyc + 1;
    for (int k = 0; k < N; k++) cq[k].push_back('{cyc: e + k, data: row[k*DL +: DL]});
    oq.push_back('{cyc: e + PL, last: is_last});
    if (is_last) exp_done_cyc = e + PL + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit exp_ready);
    for (int i = 0; i < n; i++) begin
      checkOutput("in_ready_idle", 64'(in_ready), 64'(exp_ready));
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_frame();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < exp_done_cyc && guard < 2000);
    checkOutput("done_reached", 64'(cyc == exp_done_cyc), 64'd1);
    checkOutput("busy_at_done", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("in_ready_after_done", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_col_data", 64'(col_data), 64'd0);
    checkOutput("rst_col_valid", 64'(col_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] frame of 3, back-to-back");
    start_frame(8'd3);
    checkOutput("busy_feed", 64'(busy), 64'd1);
    applyStimulus(32'h11111111, 1'b0);
    applyStimulus(32'h22222222, 1'b0);
    applyStimulus(32'h33333333, 1'b1);
    in_valid = 1'b1;
    in_row   = 32'h44444444;
    idle_cycles(4, 1'b0);
    in_valid = 1'b0;
    finish_frame();

    $display("[TB] frame of 4 with a 2-cycle bubble and a stray start");
    start_frame(8'd4);
    applyStimulus(32'h0403_0201, 1'b0);
    applyStimulus(32'h1413_1211, 1'b0);
    start       = 1'b1;
    num_samples = 8'd1;
    idle_cycles(2, 1'b1);
    start       = 1'b0;
    applyStimulus(32'h2423_2221, 1'b0);
    applyStimulus(32'h3433_3231, 1'b1);
    finish_frame();

    $display("[TB] empty frame");
    start_frame(8'd0);
    checkOutput("in_ready_empty", 64'(in_ready), 64'd0);
    finish_frame();

    $display("[TB] abort five cycles into FEED");
    start_frame(8'd10);
    for (int i = 0; i < 5; i++) applyStimulus(32'hA0A0A0A0 + 32'(i), 1'b0);
    abort    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_row   = 32'hBADBADBA;
    @(posedge clk); #1;
    abort    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    flush_expectations();
    checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    idle_cycles(PL + 4, 1'b0);
    start_frame(8'd2);
    applyStimulus(32'h5A5A5A5A, 1'b0);
    applyStimulus(32'hC3C3C3C3, 1'b1);
    finish_frame();

    $display("[TB] reset during DRAIN");
    start_frame(8'd3);
    applyStimulus(32'h01020304, 1'b0);
    applyStimulus(32'h05060708, 1'b0);
    applyStimulus(32'h090A0B0C, 1'b1);
    idle_cycles(5, 1'b0);
    #2 rst_n = 1'b0;
    flush_expectations();
    exp_done_cyc = -1;
    #1;
    checkOutput("rstmid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rstmid_out_last", 64'(out_last), 64'd0);
    checkOutput("rstmid_col_valid", 64'(col_valid), 64'd0);
    checkOutput("rstmid_col_data", 64'(col_data), 64'd0);
    checkOutput("rstmid_busy", 64'(busy), 64'd0);
    checkOutput("rstmid_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rstrel_busy", 64'(busy), 64'd0);
    idle_cycles(PL + 4, 1'b0);
    start_frame(8'd1);
    applyStimulus(32'hDEADBEEF, 1'b1);
    finish_frame();

    checkOutput("queues_drained", 64'(cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size() + oq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
